// File: rtl/xcipher_pkg.sv
// Shared types and constants for the xcipher multi-round cipher engine.
package xcipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/xcipher_round.sv
// One cipher round: encrypt rotl(~(d^k)) or its exact inverse ~rotr(d)^k.
module xcipher_round
    import xcipher_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROT   = 2
) (
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] k,
    input  logic             mode,
    output logic [WIDTH-1:0] d_next
);

    logic [WIDTH-1:0] mix;
    logic [WIDTH-1:0] rot_r;

    always_comb begin
        mix   = ~(d ^ k);
        rot_r = (d >> ROT) | (d << (WIDTH - ROT));
        if (mode == MODE_ENC) begin
            d_next = (mix << ROT) | (mix >> (WIDTH - ROT));
        end else begin
            d_next = ~rot_r ^ k;
        end
    end

endmodule

// File: rtl/xcipher_core.sv
// Multi-round cipher engine: accept one word, run N rounds (one per clock),
// present the result on a backpressured output port; abortable.
module xcipher_core
    import xcipher_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ROT   = 2,
    parameter int unsigned RW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [WIDTH-1:0] in_key_i,
    input  logic [RW-1:0]    in_rounds_i,
    input  logic             in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_mode_o,
    input  logic             abort_i,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [RW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_mode_q, res_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] round_out;

    xcipher_round #(
        .WIDTH (WIDTH),
        .ROT   (ROT)
    ) u_round (
        .d      (data_q),
        .k      (key_q),
        .mode   (mode_q),
        .d_next (round_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        key_d       = key_q;
        mode_d      = mode_q;
        res_d       = res_q;
        res_mode_d  = res_mode_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    data_d = in_data_i;
                    key_d  = in_key_i;
                    mode_d = in_mode_i;
                    cnt_d  = in_rounds_i;
                    // Zero rounds bypasses RUN and publishes the input directly.
                    if (in_rounds_i == '0) begin
                        res_d       = in_data_i;
                        res_mode_d  = in_mode_i;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    data_d = round_out;
                    cnt_d  = cnt_q - RW'(1);
                    if (cnt_q == RW'(1)) begin
                        res_d       = round_out;
                        res_mode_d  = mode_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort_i || out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            key_q       <= '0;
            mode_q      <= MODE_ENC;
            res_q       <= '0;
            res_mode_q  <= MODE_ENC;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            res_q       <= res_d;
            res_mode_q  <= res_mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = res_q;
    assign out_mode_o  = res_mode_q;

endmodule

// File: tb/tb_xcipher_core.sv
// Self-checking bench for xcipher_core (WIDTH=8, ROT=2, RW=4).
module tb_xcipher_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready_o;
    logic [7:0] in_data;
    logic [7:0] in_key;
    logic [3:0] in_rounds;
    logic       in_mode;
    logic       out_valid_o;
    logic       out_ready;
    logic [7:0] out_data_o;
    logic       out_mode_o;
    logic       abort;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb[$];
    logic [8:0] sb_e;

    always #5 clk = ~clk;

    xcipher_core #(
        .WIDTH (8),
        .ROT   (2),
        .RW    (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .in_key_i    (in_key),
        .in_rounds_i (in_rounds),
        .in_mode_i   (in_mode),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_o),
        .out_mode_o  (out_mode_o),
        .abort_i     (abort),
        .busy_o      (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_round(input logic [7:0] d, input logic [7:0] k, input logic m);
        logic [7:0] t;
        if (m == 1'b0) begin
            t = ~(d ^ k);
            return {t[5:0], t[7:6]};
        end
        t = {d[1:0], d[7:2]};
        return (~t) ^ k;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] k, input int n, input logic m);
        logic [7:0] r = d;
        for (int i = 0; i < n; i++) r = model_round(r, k, m);
        return r;
    endfunction

    // Scoreboard: compare whenever a result handshake is about to happen.
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready && !abort) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                chk("out_data", {24'd0, out_data_o}, {24'd0, sb_e[7:0]});
                chk("out_mode", {31'd0, out_mode_o}, {31'd0, sb_e[8]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready_o && t < 50) begin
            cyc();
            t++;
        end
        if (!in_ready_o) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept(input logic [7:0] d, input logic [7:0] k, input logic [3:0] n, input logic m);
        wait_idle();
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        in_rounds = n;
        in_mode   = m;
        cyc();
        in_valid  = 1'b0;
        in_data   = $urandom_range(0, 255);
        in_key    = $urandom_range(0, 255);
        in_rounds = $urandom_range(0, 15);
        in_mode   = ~m;
    endtask

    task automatic run_op(input logic [7:0] d, input logic [7:0] k, input logic [3:0] n,
                          input logic m, input int hold, input logic [7:0] exp);
        int lat = 0;
        logic [7:0] held;
        sb.push_back({m, exp});
        accept(d, k, n, m);
        while (!out_valid_o && lat < 20) begin
            cyc();
            lat++;
        end
        chk("latency", lat, {28'd0, n});
        held = out_data_o;
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
            chk("bp_ready_low", {31'd0, in_ready_o}, 32'd0);
            chk("bp_data_stable", {24'd0, out_data_o}, {24'd0, held});
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid_o}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready_o}, 32'd1);
        chk("post_hs_data_kept", {24'd0, out_data_o}, {24'd0, exp});
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] k;
        logic [3:0] n;
        logic       m;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] ct;
    int quiet;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h3C, 8'h5A, 4'd1, 1'b0, 5, 8'h66};
        vecs[1] = '{8'h66, 8'h5A, 4'd1, 1'b1, 0, 8'h3C};
        vecs[2] = '{8'hA5, 8'h00, 4'd0, 1'b0, 2, 8'hA5};
        vecs[3] = '{8'hA5, 8'hFF, 4'd0, 1'b1, 0, 8'hA5};
        vecs[4] = '{8'hC3, 8'h0F, 4'd7, 1'b0, 1, model(8'hC3, 8'h0F, 7, 1'b0)};
        vecs[5] = '{8'h81, 8'hE7, 4'd15, 1'b1, 0, model(8'h81, 8'hE7, 15, 1'b1)};
        vecs[6] = '{8'h00, 8'h00, 4'd2, 1'b0, 0, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; in_rounds = '0;
        in_mode = 1'b0; out_ready = 1'b0; abort = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_out_data", {24'd0, out_data_o}, 32'd0);
        chk("rst_out_mode", {31'd0, out_mode_o}, 32'd0);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].d, vecs[i].k, vecs[i].n, vecs[i].m, vecs[i].hold, vecs[i].exp);

        // Round trip over 15 rounds.
        ct = model(8'h12, 8'h34, 15, 1'b0);
        run_op(8'h12, 8'h34, 4'd15, 1'b0, 0, ct);
        run_op(ct, 8'h34, 4'd15, 1'b1, 0, 8'h12);

        // Abort during round 3 of 10.
        accept(8'h55, 8'hAA, 4'd10, 1'b0);
        cyc();
        cyc();
        chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_valid", {31'd0, out_valid_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready_o}, 32'd1);
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid_o) quiet++;
            cyc();
        end
        chk("abort_no_output", quiet, 32'd0);
        run_op(8'h3C, 8'h5A, 4'd1, 1'b0, 0, 8'h66);

        // Abort in DONE beats a simultaneous out_ready.
        accept(8'h66, 8'h5A, 4'd1, 1'b1);
        cyc();
        chk("done_valid", {31'd0, out_valid_o}, 32'd1);
        abort = 1'b1;
        out_ready = 1'b1;
        cyc();
        abort = 1'b0;
        out_ready = 1'b0;
        chk("done_abort_valid", {31'd0, out_valid_o}, 32'd0);
        chk("done_abort_idle", {31'd0, in_ready_o}, 32'd1);
        chk("done_abort_data_kept", {24'd0, out_data_o}, 32'h3C);
        chk("done_abort_mode_kept", {31'd0, out_mode_o}, 32'd1);

        // Asynchronous reset mid-RUN.
        accept(8'h5A, 8'h3C, 4'd9, 1'b1);
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("midrst_data", {24'd0, out_data_o}, 32'd0);
        chk("midrst_mode", {31'd0, out_mode_o}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();
        run_op(8'hC3, 8'h0F, 4'd7, 1'b0, 0, model(8'hC3, 8'h0F, 7, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
